// File: rtl/uart_loader_ctrl.sv
// UART boot loader: frames SYNC, LEN16, words, XOR checksum into imem.
// Ports: clk, reset, rx_data/rx_done in; mem_we/addr/wdata, cpu_hold, load_done, error out.
module uart_loader_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 2000000,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        error
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        rx_done_q;
  logic [7:0]  len_lo;
  logic [15:0] words_left;
  logic [1:0]  index;
  logic [23:0] word_buf;
  logic [7:0]  checksum;
  logic [31:0] tmo_cnt;

  logic acc;
  logic tmo_hit;
  logic start;
  logic word_wr;
  logic sum_ok;
  logic sum_bad;

  assign acc = rx_done & ~rx_done_q;

  // An accepted byte in the same cycle wins over the timeout.
  assign tmo_hit = (state_q != S_IDLE) && !acc
                && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    word_wr = 1'b0;
    sum_ok  = 1'b0;
    sum_bad = 1'b0;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (acc) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC) begin
            state_d = S_LEN_LO;
            start   = 1'b1;
          end
        end
        S_LEN_LO: state_d = S_LEN_HI;
        S_LEN_HI: begin
          if ({rx_data, len_lo} == 16'd0)
            state_d = S_CHECK;
          else
            state_d = S_DATA;
        end
        S_DATA: begin
          if (index == 2'd3) begin
            word_wr = 1'b1;
            if (words_left == 16'd1)
              state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          state_d = S_IDLE;
          if (rx_data == checksum) sum_ok  = 1'b1;
          else                     sum_bad = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_q  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      error      <= 1'b0;
      len_lo     <= 8'd0;
      words_left <= 16'd0;
      index      <= 2'd0;
      word_buf   <= 24'd0;
      checksum   <= 8'd0;
      tmo_cnt    <= 32'd0;
    end else begin
      rx_done_q <= rx_done;
      mem_we    <= word_wr;
      load_done <= sum_ok;

      // Address advances once the strobed word is out.
      if (mem_we)
        mem_addr <= mem_addr + 32'd4;

      if (state_q == S_IDLE || acc)
        tmo_cnt <= 32'd0;
      else
        tmo_cnt <= tmo_cnt + 32'd1;

      if (start) begin
        cpu_hold <= 1'b1;
        error    <= 1'b0;
        mem_addr <= BASE_ADDR;
        checksum <= 8'd0;
        index    <= 2'd0;
      end

      if (acc && state_q == S_LEN_LO)
        len_lo <= rx_data;

      if (acc && state_q == S_LEN_HI) begin
        words_left <= {rx_data, len_lo};
        index      <= 2'd0;
      end

      if (acc && state_q == S_DATA) begin
        checksum <= checksum ^ rx_data;
        index    <= index + 2'd1;
        unique case (index)
          2'd0: word_buf[7:0]   <= rx_data;
          2'd1: word_buf[15:8]  <= rx_data;
          2'd2: word_buf[23:16] <= rx_data;
          2'd3: begin
            mem_wdata  <= {rx_data, word_buf};
            words_left <= words_left - 16'd1;
          end
          default: ;
        endcase
      end

      if (sum_ok || sum_bad || tmo_hit)
        cpu_hold <= 1'b0;
      if (sum_bad || tmo_hit)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Directed bench for uart_loader_ctrl.
// Byte-level stimulus, negedge monitor, immediate-assertion checks.
module tb_uart_loader_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        error;

  int n_tests;
  int n_fail;
  int we_cnt;
  int ld_cnt;
  int both_cnt;
  logic [31:0] we_addr [0:7];
  logic [31:0] we_data [0:7];

  uart_loader_ctrl #(
    .BASE_ADDR(32'h0000_0000),
    .TIMEOUT  (100),
    .SYNC     (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      if (we_cnt < 8) begin
        we_addr[we_cnt] = mem_addr;
        we_data[we_cnt] = mem_wdata;
      end
      we_cnt = we_cnt + 1;
    end
    if (load_done) ld_cnt = ld_cnt + 1;
    if (mem_we && load_done) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    we_cnt = 0;
    ld_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (2) @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    we_cnt   = 0;
    ld_cnt   = 0;
    both_cnt = 0;
    rx_data  = 8'h00;
    rx_done  = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(mem_we),    32'd0);
    chk("rst_addr",  mem_addr,       32'h0);
    chk("rst_wdata", mem_wdata,      32'h0);
    chk("rst_hold",  32'(cpu_hold),  32'd0);
    chk("rst_done",  32'(load_done), 32'd0);
    chk("rst_err",   32'(error),     32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // One-word good frame
    clr();
    send(8'hA5);
    chk("t1_hold_on", 32'(cpu_hold), 32'd1);
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("t1_we_cnt", 32'(we_cnt), 32'd1);
    chk("t1_addr",   we_addr[0],  32'h0);
    chk("t1_data",   we_data[0],  32'hDEADBEEF);
    chk("t1_hold_mid", 32'(cpu_hold), 32'd1);
    send(8'h22);
    chk("t1_ld_cnt", 32'(ld_cnt),   32'd1);
    chk("t1_err",    32'(error),    32'd0);
    chk("t1_hold_off", 32'(cpu_hold), 32'd0);

    // Two words, bad checksum (good one is 08)
    clr();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    send(8'hFF);
    chk("t2_we_cnt", 32'(we_cnt),  32'd2);
    chk("t2_addr0",  we_addr[0],   32'h0);
    chk("t2_addr1",  we_addr[1],   32'h4);
    chk("t2_data0",  we_data[0],   32'h04030201);
    chk("t2_data1",  we_data[1],   32'h08070605);
    chk("t2_err",    32'(error),   32'd1);
    chk("t2_ld",     32'(ld_cnt),  32'd0);
    chk("t2_hold",   32'(cpu_hold), 32'd0);

    // Zero-length frames
    clr();
    send(8'hA5);
    chk("t3_err_clr", 32'(error), 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    chk("t3_we",   32'(we_cnt), 32'd0);
    chk("t3_ld",   32'(ld_cnt), 32'd1);
    chk("t3_err",  32'(error),  32'd0);
    clr();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
    chk("t3b_err", 32'(error),  32'd1);
    chk("t3b_ld",  32'(ld_cnt), 32'd0);

    // Timeout inside a partial word
    clr();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE);
    chk("t4_hold_pre", 32'(cpu_hold), 32'd1);
    repeat (110) @(negedge clk);
    chk("t4_err",  32'(error),    32'd1);
    chk("t4_hold", 32'(cpu_hold), 32'd0);
    chk("t4_we",   32'(we_cnt),   32'd0);
    send(8'hA5);
    chk("t4_err_clr", 32'(error),  32'd0);
    chk("t4_hold_on", 32'(cpu_hold), 32'd1);

    // Reset mid-DATA
    send(8'h01); send(8'h00); send(8'hEF);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_hold", 32'(cpu_hold),  32'd0);
    chk("t5_err",  32'(error),     32'd0);
    chk("t5_we",   32'(mem_we),    32'd0);
    chk("t5_addr", mem_addr,       32'h0);
    chk("t5_wd",   mem_wdata,      32'h0);
    chk("t5_ld",   32'(load_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clr();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h22);
    chk("t5_we_cnt", 32'(we_cnt), 32'd1);
    chk("t5_addr0",  we_addr[0],  32'h0);
    chk("t5_data0",  we_data[0],  32'hDEADBEEF);
    chk("t5_ldc",    32'(ld_cnt), 32'd1);

    // Held level across reset release, then IDLE noise
    clr();
    @(negedge clk);
    reset   = 1'b1;
    rx_data = 8'hA5;
    rx_done = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    send(8'h00); send(8'h00); send(8'h00);
    chk("t6_ld",   32'(ld_cnt), 32'd1);
    chk("t6_err",  32'(error),  32'd0);
    clr();
    send(8'h3C); send(8'h11);
    chk("t6_ign_hold", 32'(cpu_hold), 32'd0);
    chk("t6_ign_we",   32'(we_cnt),   32'd0);
    chk("t6_ign_ld",   32'(ld_cnt),   32'd0);

    chk("we_ld_overlap", 32'(both_cnt), 32'd0);

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader_ctrl.md
UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of the first word written.
REQ-002 SHALL have parameter TIMEOUT, default 2000000, the maximum clk cycles allowed between accepted bytes inside a frame.
REQ-003 SHALL have parameter SYNC, default 8'hA5, the frame start byte.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset; asynchronous and active-high.
REQ-006 rx_data  input  8  received byte from the UART receiver; valid when rx_done rises.
REQ-007 rx_done  input  1  byte-ready flag from the UART receiver, level; one byte is accepted per 0->1 transition.
REQ-008 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 mem_addr  output  32  word-aligned write address.
REQ-010 mem_wdata  output  32  assembled write word.
REQ-011 cpu_hold  output  1  holds the core in reset while a load is in progress.
REQ-012 load_done  output  1  one-cycle pulse on successful frame completion.
REQ-013 error  output  1  sticky flag for a failed frame.

Function
REQ-014 SHALL register rx_done and treat (rx_done & ~rx_done_q) as the byte-accept event "acc"; a level held high accepts exactly one byte.
REQ-015 SHALL implement the FSM states IDLE, LEN_LO, LEN_HI, DATA, CHECK.
REQ-016 IDLE: on acc with rx_data==SYNC -> LEN_LO, cpu_hold<=1, error<=0, mem_addr<=BASE_ADDR, checksum<=0; other bytes are ignored.
REQ-017 LEN_LO: on acc, latch count[7:0] -> LEN_HI.
REQ-018 LEN_HI: on acc, latch count[15:8]; if the full 16-bit count is 0 -> CHECK, else -> DATA with byte index 0.
REQ-019 DATA: each acc places rx_data into byte lane [index] of the word (little-endian, lane 0 first), XORs it into the 8-bit checksum, and increments the 2-bit index.
REQ-020 DATA: the acc with index==3 SHALL drive mem_we=1 for exactly the next cycle, with mem_wdata = the complete word and mem_addr = the current address.
REQ-021 mem_addr SHALL increment by 4 in the cycle after each mem_we; it wraps modulo 2^32 with no flag.
REQ-022 DATA: after the last word of the count is written -> CHECK; words remaining is a 16-bit down-counter.
REQ-023 CHECK: on acc, if rx_data==checksum, pulse load_done for 1 cycle; else set error<=1. In both cases cpu_hold<=0 -> IDLE.
REQ-024 A SYNC-valued byte received outside IDLE SHALL be treated as ordinary length/data/checksum content.
REQ-025 SHALL run an inactivity counter in every state except IDLE, cleared on each acc; when it reaches TIMEOUT-1: error<=1, cpu_hold<=0, -> IDLE, and no mem_we is issued for a partial word.
REQ-026 Words already written before a checksum error or timeout SHALL remain written; there is no rollback.
REQ-027 mem_we and load_done SHALL never be asserted in the same cycle.
REQ-028 error SHALL stay at 1 until reset or the next SYNC accepted in IDLE.

Reset
REQ-029 Reset SHALL force, asynchronously and at any point including mid-frame: state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, load_done=0, error=0, checksum=0, index=0, counters=0, rx_done_q=0.
REQ-030 After reset release, rx_done already high SHALL be accepted as a byte only if it was low in the previous cycle (rx_done_q=0 means a held-high level is accepted once).

Verification
REQ-031 Bytes A5 01 00 EF BE AD DE 22 -> one mem_we, addr 0x0, wdata 0xDEADBEEF; load_done pulses once; error=0; cpu_hold high from the A5 until the 0x22.
REQ-032 Bytes A5 02 00 followed by 8 data bytes and a wrong checksum -> mem_we at 0x0 and then 0x4; error=1; load_done never asserted; cpu_hold returns to 0.
REQ-033 Bytes A5 00 00 00 -> no mem_we, load_done pulses once; the same with a final 0x01 -> error=1.
REQ-034 TIMEOUT=100; send A5 01 00 EF BE, then stall 100 cycles -> error=1, cpu_hold=0, state IDLE, no mem_we; the next A5 clears error.
REQ-035 Assert reset mid-DATA -> all outputs reach reset values immediately; a following correct frame loads at BASE_ADDR.
REQ-036 Hold rx_done high for 50 cycles with rx_data=A5 -> exactly one byte accepted (state LEN_LO); bytes 3C, 11 in IDLE -> ignored.
